// File: rtl/localbus_arbiter_pkg.sv
// Shared widths, FSM encodings, master IDs and the read-tracker tag.
package localbus_arbiter_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned WE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    localparam logic [WE_W-1:0] WE_READ = 3'b000;

    // One slot of the read-response tracker.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/localbus_arbiter_if.sv
// Per-master local-bus port: request side driven by the master, grant/response by the arbiter.
interface localbus_arbiter_if;
    import localbus_arbiter_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] qin;
    logic [WE_W-1:0] we;
    logic            gnt;
    logic [XLEN-1:0] qout;
    logic            rvalid;

    modport master (output req, addr, qin, we, input  gnt, qout, rvalid);
    modport slave  (input  req, addr, qin, we, output gnt, qout, rvalid);

endinterface

// File: rtl/localbus_arbiter_rdtrack.sv
// Shift register of {valid, id} tags that lines each read response up with its issuer.
module localbus_arbiter_rdtrack
    import localbus_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t push_i,
    output rd_tag_t tail_o
);

    rd_tag_t stage_q [DEPTH];

    // Head slot takes the tag of the beat accepted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q[0] <= '0;
        end else begin
            stage_q[0] <= push_i;
        end
    end

    for (genvar g = 1; g < DEPTH; g++) begin : g_stage
        // Remaining slots shift one step toward the tail each cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q[g] <= '0;
            end else begin
                stage_q[g] <= stage_q[g-1];
            end
        end
    end

    assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/localbus_arbiter.sv
// Two-master round-robin arbiter with bounded bursts in front of the local bus.
module localbus_arbiter
    import localbus_arbiter_pkg::*;
#(
    parameter int unsigned RDLAT    = 1,
    parameter int unsigned MAXBURST = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    localbus_arbiter_if.slave   m0,
    localbus_arbiter_if.slave   m1,
    output logic [XLEN-1:0]     addr_o,
    output logic [XLEN-1:0]     qin_o,
    output logic [WE_W-1:0]     we_o,
    input  logic [XLEN-1:0]     qout_i
);

    localparam int unsigned   CNT_W   = $clog2(MAXBURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXBURST);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             last_q, last_d;
    logic             own_id, own_req, oth_req;
    state_e           other_st;
    rd_tag_t          push, tail;

    // Current owner's identity and the two request lines seen from its side.
    always_comb begin
        own_id   = (state_q == ST_OWN1) ? ID_M1 : ID_M0;
        other_st = (state_q == ST_OWN0) ? ST_OWN1 : ST_OWN0;
        own_req  = 1'b0;
        oth_req  = 1'b0;
        if (state_q == ST_OWN0) begin
            own_req = m0.req;
            oth_req = m1.req;
        end else if (state_q == ST_OWN1) begin
            own_req = m1.req;
            oth_req = m0.req;
        end
    end

    // Next-state, burst counter and last-owner pointer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (m0.req && m1.req) begin
                    state_d = (last_q == ID_M0) ? ST_OWN1 : ST_OWN0;
                end else if (m0.req) begin
                    state_d = ST_OWN0;
                end else if (m1.req) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                last_d = own_id;
                if (!own_req) begin
                    state_d = oth_req ? other_st : ST_IDLE;
                    cnt_d   = '0;
                end else if ((cnt_inc == CNT_MAX) && oth_req) begin
                    state_d = other_st;
                    cnt_d   = '0;
                end else begin
                    // Saturates while the other master is idle: owner keeps the bus.
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and pointer registers; pointer resets so master 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= ID_M1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign m0.gnt = (state_q == ST_OWN0);
    assign m1.gnt = (state_q == ST_OWN1);

    // Bus mux: drive the owner's beat, otherwise a quiet read of address 0.
    always_comb begin
        addr_o = '0;
        qin_o  = '0;
        we_o   = WE_READ;
        if (own_req) begin
            if (own_id == ID_M1) begin
                addr_o = m1.addr;
                qin_o  = m1.qin;
                we_o   = m1.we;
            end else begin
                addr_o = m0.addr;
                qin_o  = m0.qin;
                we_o   = m0.we;
            end
        end
    end

    assign push = '{valid: own_req && (we_o == WE_READ), id: own_id};

    localbus_arbiter_rdtrack #(
        .DEPTH (RDLAT)
    ) u_rdtrack (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .tail_o (tail)
    );

    assign m0.rvalid = tail.valid && (tail.id == ID_M0);
    assign m1.rvalid = tail.valid && (tail.id == ID_M1);
    assign m0.qout   = qout_i;
    assign m1.qout   = qout_i;

endmodule

// File: tb/tb_localbus_arbiter.sv
// Directed bench for localbus_arbiter: vector table plus burst, saturation and reset sequences.
module tb_localbus_arbiter;

    localparam int unsigned RDLAT    = 2;
    localparam int unsigned MAXBURST = 8;

    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] Q1 = 32'hA5A5_0001;
    localparam logic [31:0] Q2 = 32'hA5A5_0002;
    localparam logic [31:0] Q3 = 32'hA5A5_0003;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_o, qin_o, qout_i;
    logic [2:0]  we_o;
    logic [31:0] ap0 = '0;
    logic [31:0] ap1 = '0;

    localbus_arbiter_if m0_if ();
    localbus_arbiter_if m1_if ();

    localbus_arbiter #(
        .RDLAT    (RDLAT),
        .MAXBURST (MAXBURST)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m0     (m0_if),
        .m1     (m1_if),
        .addr_o (addr_o),
        .qin_o  (qin_o),
        .we_o   (we_o),
        .qout_i (qout_i)
    );

    always #5 clk = ~clk;

    // Bus model: read data appears RDLAT cycles after the address, tagged by address.
    always @(posedge clk) begin
        ap0 <= addr_o;
        ap1 <= ap0;
    end
    assign qout_i = 32'hA5A5_0000 | (ap1 >> 4);

    typedef struct {
        logic        r0;
        logic [2:0]  w0;
        logic [31:0] a0, d0;
        logic        r1;
        logic [2:0]  w1;
        logic [31:0] a1, d1;
        logic        g0, g1;
        logic [2:0]  ewe;
        logic [31:0] eaddr, eqin;
        logic        v0, v1;
        logic [31:0] eq;
    } vec_t;

    vec_t tab[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic r0, input logic [2:0] w0, input logic [31:0] a0,
                                input logic [31:0] d0, input logic r1, input logic [2:0] w1,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic g0, input logic g1, input logic [2:0] ewe,
                                input logic [31:0] eaddr, input logic [31:0] eqin,
                                input logic v0, input logic v1, input logic [31:0] eq);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.ewe = ewe; v.eaddr = eaddr; v.eqin = eqin;
        v.v0 = v0; v.v1 = v1; v.eq = eq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic [2:0] w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic [2:0] w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.qin = d0;
        m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.qin = d1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 3'd0, 0, 0, 0, 3'd0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    vec_t v;
    int   own_h [100];
    int   b0, b1, own;

    initial begin
        // r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 | we addr qin | v0 v1 qout
        tab.push_back(mk(0,0,0,0,      0,0,0,0,        0,0, 0,0,0,        0,0,0));
        tab.push_back(mk(1,0,'h10,D0,  0,0,0,0,        0,0, 0,0,0,        0,0,0));
        tab.push_back(mk(1,0,'h10,D0,  0,0,0,0,        1,0, 0,'h10,D0,    0,0,0));
        tab.push_back(mk(1,0,'h10,D0,  0,0,0,0,        1,0, 0,'h10,D0,    0,0,0));
        tab.push_back(mk(0,0,0,0,      0,0,0,0,        1,0, 0,0,0,        1,0,Q1));
        tab.push_back(mk(0,0,0,0,      0,0,0,0,        0,0, 0,0,0,        1,0,Q1));
        tab.push_back(mk(0,0,0,0,      1,7,'h40,DB,    0,0, 0,0,0,        0,0,0));
        tab.push_back(mk(0,0,0,0,      1,7,'h40,DB,    0,1, 7,'h40,DB,    0,0,0));
        tab.push_back(mk(1,0,'h20,D0,  0,0,0,0,        0,1, 0,0,0,        0,0,0));
        tab.push_back(mk(1,0,'h20,D0,  0,0,0,0,        1,0, 0,'h20,D0,    0,0,0));
        tab.push_back(mk(0,0,0,0,      1,0,'h30,0,     1,0, 0,0,0,        0,0,0));
        tab.push_back(mk(0,0,0,0,      1,0,'h30,0,     0,1, 0,'h30,0,     1,0,Q2));
        tab.push_back(mk(0,0,0,0,      0,0,0,0,        0,1, 0,0,0,        0,0,0));
        tab.push_back(mk(0,0,0,0,      0,0,0,0,        0,0, 0,0,0,        0,1,Q3));
        tab.push_back(mk(1,0,'h10,D0,  1,0,'h30,0,     0,0, 0,0,0,        0,0,0));
        tab.push_back(mk(1,0,'h10,D0,  1,0,'h30,0,     1,0, 0,'h10,D0,    0,0,0));
        tab.push_back(mk(0,0,0,0,      1,0,'h30,0,     1,0, 0,0,0,        0,0,0));
        tab.push_back(mk(0,0,0,0,      1,0,'h30,0,     0,1, 0,'h30,0,     1,0,Q1));
        tab.push_back(mk(0,0,0,0,      0,0,0,0,        0,1, 0,0,0,        0,0,0));
        tab.push_back(mk(0,0,0,0,      0,0,0,0,        0,0, 0,0,0,        0,1,Q3));
        tab.push_back(mk(0,0,0,0,      0,0,0,0,        0,0, 0,0,0,        0,0,0));

        do_reset();
        for (int i = 0; i < tab.size(); i++) begin
            v = tab[i];
            @(posedge clk);
            #1 drive(v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.a1, v.d1);
            @(negedge clk);
            chk($sformatf("row%0d gnt0", i), m0_if.gnt, v.g0);
            chk($sformatf("row%0d gnt1", i), m1_if.gnt, v.g1);
            chk($sformatf("row%0d we", i), we_o, v.ewe);
            chk($sformatf("row%0d addr", i), addr_o, v.eaddr);
            chk($sformatf("row%0d qin", i), qin_o, v.eqin);
            chk($sformatf("row%0d rvalid0", i), m0_if.rvalid, v.v0);
            chk($sformatf("row%0d rvalid1", i), m1_if.rvalid, v.v1);
            if (v.v0 || v.v1) begin
                chk($sformatf("row%0d qout0", i), m0_if.qout, v.eq);
                chk($sformatf("row%0d qout1", i), m1_if.qout, v.eq);
            end
        end

        // Both masters request continuously: m0 first, bursts of MAXBURST, no idle gap.
        do_reset();
        @(posedge clk);
        #1 drive(1, 3'd0, 'h10, D0, 1, 3'd0, 'h30, 0);
        @(negedge clk);
        chk("rr arb gnt0", m0_if.gnt, 0);
        chk("rr arb gnt1", m1_if.gnt, 0);
        b0 = 0;
        b1 = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            own = (j / int'(MAXBURST)) % 2;
            own_h[j] = own;
            chk($sformatf("rr%0d gnt0", j), m0_if.gnt, 32'(own == 0));
            chk($sformatf("rr%0d gnt1", j), m1_if.gnt, 32'(own == 1));
            if (j >= int'(RDLAT)) begin
                chk($sformatf("rr%0d rvalid0", j), m0_if.rvalid, 32'(own_h[j-2] == 0));
                chk($sformatf("rr%0d rvalid1", j), m1_if.rvalid, 32'(own_h[j-2] == 1));
                chk($sformatf("rr%0d qout", j), m0_if.qout, (own_h[j-2] == 0) ? Q1 : Q3);
            end else begin
                chk($sformatf("rr%0d rvalid0", j), m0_if.rvalid, 0);
                chk($sformatf("rr%0d rvalid1", j), m1_if.rvalid, 0);
            end
            if (m0_if.gnt) b0++;
            if (m1_if.gnt) b1++;
        end
        chk("rr beats0", b0, 52);
        chk("rr beats1", b1, 48);
        chk("rr fairness", 32'((b0 - b1 <= int'(MAXBURST)) && (b1 - b0 <= int'(MAXBURST))), 1);

        // Counter saturates while m1 is idle; m1's first request then switches after one beat.
        do_reset();
        for (int j = 0; j < 16; j++) begin
            @(posedge clk);
            #1 drive(1, 3'd0, 'h10, D0, 0, 3'd0, 0, 0);
            @(negedge clk);
            chk($sformatf("sat%0d gnt0", j), m0_if.gnt, 32'(j >= 1));
        end
        @(posedge clk);
        #1 drive(1, 3'd0, 'h10, D0, 1, 3'd0, 'h30, 0);
        @(negedge clk);
        chk("sat hold gnt0", m0_if.gnt, 1);
        chk("sat hold gnt1", m1_if.gnt, 0);
        @(negedge clk);
        chk("sat switch gnt0", m0_if.gnt, 0);
        chk("sat switch gnt1", m1_if.gnt, 1);

        // Short reset pulse right after a read is accepted drops the in-flight response.
        do_reset();
        @(posedge clk);
        #1 drive(1, 3'd0, 'h10, D0, 0, 3'd0, 0, 0);
        @(negedge clk);
        chk("rst idle gnt0", m0_if.gnt, 0);
        @(negedge clk);
        chk("rst accept gnt0", m0_if.gnt, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("rst gnt0", m0_if.gnt, 0);
        chk("rst gnt1", m1_if.gnt, 0);
        chk("rst we", we_o, 0);
        chk("rst addr", addr_o, 0);
        chk("rst qin", qin_o, 0);
        chk("rst rvalid0", m0_if.rvalid, 0);
        chk("rst rvalid1", m1_if.rvalid, 0);
        #1 rst_n = 1'b1;
        drive(0, 3'd0, 0, 0, 0, 3'd0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("post rst%0d rvalid0", j), m0_if.rvalid, 0);
            chk($sformatf("post rst%0d rvalid1", j), m1_if.rvalid, 0);
            chk($sformatf("post rst%0d gnt0", j), m0_if.gnt, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/localbus_arbiter.md
# localbus_arbiter

Two-master arbiter placed in front of the local bus (data RAM, GPIO, VGA regions). It shares the single bus port between the core data port (master 0) and a secondary master such as a DMA or debug port (master 1) using round-robin grants with bounded bursts. It routes each read response back to the master that issued it, including across grant switches.

## Interface
- XLEN, 32, bus data/address width (from core_general.vh)
- RDLAT, 1, bus read latency in cycles from address to valid qout (1..4)
- MAXBURST, 8, max consecutive accepted beats for one owner while the other master requests (2..255)
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  master requests a transfer this cycle
- m0_addr / m1_addr  in  XLEN  address
- m0_qin / m1_qin  in  XLEN  write data
- m0_we / m1_we  in  3  write enable; 3'b000 with req means read
- m0_gnt / m1_gnt  out  1  master owns the bus; a beat is accepted when req && gnt
- m0_qout / m1_qout  out  XLEN  read data, valid only with rvalid
- m0_rvalid / m1_rvalid  out  1  read data for this master on the current cycle
- addr  out  XLEN  to local bus
- qin  out  XLEN  to local bus
- we  out  3  to local bus
- qout  in  XLEN  from local bus

## Operation
- FSM states: IDLE, OWN0, OWN1. The grant is registered: mX_gnt = (state == OWNx).
- IDLE: if any req, go to the winner's OWN state. Winner is the master not granted most recently (last pointer). One arbitration cycle is spent.
- OWNx, req_x = 0: if req_y, go to OWNy; otherwise go to IDLE.
- OWNx, req_x = 1: increment beat counter. If counter reaches MAXBURST and req_y = 1, go to OWNy, clear the counter, and set last = x. Otherwise stay in OWNx.
- The beat counter clears on every state change. It saturates at MAXBURST while the other master is idle, so the owner keeps the bus without limit.
- Bus mux: while in OWNx, addr/qin/we are driven from master x. we is forced to 3'b000 and addr/qin to 0 when the owner's req = 0 or in IDLE.
- Read tracking: each accepted read (we == 0) pushes {valid = 1, id = x} into an RDLAT-deep shift register. Non-reads and idle cycles push valid = 0.
- At the tail: mX_rvalid = tail.valid && tail.id == x. Bus qout is broadcast to both mX_qout ports.
- Writes produce no response.
- Simultaneous first request from both masters out of IDLE after reset: master 0 wins (last pointer resets to 1).

## Timing
- Reset values: state IDLE, both gnt 0, both rvalid 0, we 3'b000, addr/qin 0, last = 1, counter 0, tracker all invalid.
- Reset mid-operation: in-flight reads are discarded and no rvalid is issued after reset releases.
- Grant latency: a req in IDLE at cycle n gives gnt at n+1; the first beat is accepted at n+1.
- Back-to-back: the owner can issue one beat per cycle. A switch between owners costs no idle cycle when the other master is already requesting.
- Read response: a read accepted at cycle n gives rvalid at n+RDLAT.
- Responses arrive in issue order regardless of grant changes. A switch at cycle n does not affect reads accepted before n.
- A master must hold req and its address/data stable until the cycle with gnt. Dropping req without gnt is legal and no beat occurs.

## Structure
- XLEN comes from core_general.vh.
- New localbus_arb.vh holds the state encodings (IDLE/OWN0/OWN1), master IDs (ID_M0 = 0, ID_M1 = 1) and the read-op encoding WE_READ = 3'b000.
- One sub-module, localbus_rdtrack: the RDLAT-deep {valid, id} shift register with reset, a push input and the tail outputs.
- localbus_arbiter instantiates localbus_rdtrack and sits directly above localbus; it has no address decoding.

## Test plan
- Reset then single master: m0 reads 0x0000_0010 continuously → m0_gnt rises one cycle after req; with the bus returning 0xA5A5_0001, m0_rvalid rises RDLAT cycles after the first beat and m1_rvalid stays 0.
- Simultaneous request after reset: both req at cycle 5 → m0_gnt at cycle 6. With MAXBURST = 8, exactly 8 m0 beats are accepted, then m1_gnt follows the next cycle with no IDLE gap.
- Fairness: both masters request continuously for 100 cycles → accepted beat counts differ by at most MAXBURST and grants alternate.
- Read across a switch with RDLAT = 2: m0's last beat is a read of 0x0000_0020 when the grant moves to m1 → m0_rvalid (not m1_rvalid) is asserted 2 cycles later carrying the bus qout.
- Writes only: m1 writes 0xDEAD_BEEF to 0x0000_0040 with we = 3'b111 → bus we = 3'b111 and qin = 0xDEAD_BEEF in the grant cycle; no rvalid is ever asserted.
- Reset mid-read: rst_n is pulled low one cycle after a read is accepted → all outputs return to reset values, and no rvalid appears after rst_n rises.
